s1488_state_reg: RTL and testbench
==================================

// Module: s1488_state_reg
// PURPOSE
//  State-register stage directly upstream of the s1488 next-state cones (the n80 cone and its siblings).
//  - Holds the six s1488 state bits v7..v12 and drives them into the combinational cones.
//  - Captures the cones' next-state bits back into the register.
//  - Provides a request/acknowledge scan path so the bench can load and unload the state serially.
//  - Counts functional captures for test-time bookkeeping.
// PARAMETERS
//  NSTATE   6          number of state bits (v7..v12)
//  CLR_VAL  6'b000000  state value loaded on reset
//  CNT_W    8          width of capture counter
// PORTS
//  CK         in   1       clock; all flops rising-edge
//  CLR        in   1       asynchronous active-low reset
//  ns_in      in   NSTATE  next-state from cones; ns_in[0]->v7 ... ns_in[5]->v12
//  cap_en     in   1       capture ns_in into state this edge (functional clock enable)
//  scan_req   in   1       1-cycle pulse: start serial shift of NSTATE bits
//  scan_in    in   1       serial data in; enters at bit NSTATE-1 (v12)
//  v7..v12    out  1 each  current state bits = state[0..5]
//  scan_out   out  1       serial data out = state[0] (v7), combinational from register
//  busy       out  1       high while FSM is in SHIFT or DONE
//  scan_ack   out  1       1-cycle pulse when shift of NSTATE bits completes
//  cap_cnt    out  CNT_W   number of captures since reset, wraps
// BEHAVIOUR
//  Reset (CLR=0, async):
//   - state=CLR_VAL; FSM=IDLE; shift counter=0; scan_ack=0; busy=0; cap_cnt=0.
//   - scan_out therefore equals CLR_VAL[0].
//   - Effective immediately; release is sampled on the next CK edge.
//  FSM states: IDLE, SHIFT, DONE.
//  IDLE:
//   - scan_req=1: go to SHIFT, state holds, counter=0, no capture.
//     scan_req takes priority over a simultaneous cap_en.
//   - else cap_en=1: state<=ns_in; cap_cnt<=cap_cnt+1 (mod 2^CNT_W, 255->0 at default).
//   - else: state holds.
//  SHIFT:
//   - Every edge: state<={scan_in,state[NSTATE-1:1]}; counter+1.
//   - On the edge where counter reaches NSTATE-1 (the NSTATE-th shift): go to DONE.
//   - Shift latency: exactly NSTATE edges; old v7 first on scan_out, old v12 last.
//   - cap_en and scan_req are ignored; cap_cnt holds.
//  DONE:
//   - scan_ack=1 for exactly this one cycle; state holds; next edge -> IDLE.
//   - cap_en and scan_req are ignored during DONE.
//  busy=1 in SHIFT and DONE, 0 in IDLE. scan_ack=0 in all states except DONE.
//  Reset asserted in SHIFT or DONE aborts the operation:
//   - no scan_ack is issued and state = CLR_VAL.
//   - A partially shifted value is never retained.
//  Output timing:
//   - v7..v12 are registered outputs with no combinational path from inputs.
//   - The cone outputs return as ns_in in the same cycle; there is no loop inside this block.
//  Outputs are never X after reset, whatever cap_en, scan_req or scan_in do.
// TESTING
//  1 Reset: drive CLR=0 mid-cycle -> v7..v12=0, cap_cnt=0, busy=0 immediately, without waiting for a CK edge.
//  2 Capture: ns_in=6'b101101, cap_en=1 for one edge -> {v12..v7}=101101, cap_cnt=1.
//    Then hold cap_en=0 for 3 cycles -> state unchanged.
//  3 Scan: state=6'b000111, scan_req pulse, scan_in=1,0,1,0,1,0 over 6 edges:
//    - scan_out sequence = 1,1,1,0,0,0.
//    - Final state = 6'b010101.
//    - busy high for 7 cycles; scan_ack high on cycle 7 only.
//  4 Priority: scan_req=1 and cap_en=1 on the same edge in IDLE -> FSM enters SHIFT, no capture, cap_cnt unchanged.
//    cap_en pulses during SHIFT are ignored.
//  5 Abort: CLR=0 at shift 3 of 6 -> state=0, busy=0, no scan_ack.
//    A new scan_req after release completes normally.
//  6 Wrap: 256 consecutive captures -> cap_cnt returns to 0.
//    State tracks the final ns_in on each edge.

Source files
------------

// File: rtl/s1488_state_reg.sv
// Purpose : s1488 state register (v7..v12) with a serial scan path and a capture counter.
// Latency : capture is 1 edge; a scan shift takes NSTATE edges plus one DONE cycle carrying scan_ack.
// Backpr. : none; scan_req and cap_en are ignored while busy, and scan_req beats cap_en in IDLE.
//
// Ports:
//   CK, CLR        clock (rising edge) and asynchronous active-low reset
//   ns_in          next-state bits from the cones, ns_in[0] -> v7 ... ns_in[5] -> v12
//   cap_en         functional capture enable
//   scan_req       one-cycle pulse that starts a serial shift of NSTATE bits
//   scan_in        serial input, enters at the top bit (v12)
//   v7..v12        registered state bits, state[0..5]
//   scan_out       serial output = state[0] (v7)
//   busy           high while shifting or in the acknowledge cycle
//   scan_ack       one-cycle pulse after the last shift
//   cap_cnt        count of captures since reset; wraps
module s1488_state_reg #(
    parameter int                 NSTATE  = 6,
    parameter logic [NSTATE-1:0]  CLR_VAL = '0,
    parameter int                 CNT_W   = 8
) (
    input  logic              CK,
    input  logic              CLR,
    input  logic [NSTATE-1:0] ns_in,
    input  logic              cap_en,
    input  logic              scan_req,
    input  logic              scan_in,
    output logic              v7,
    output logic              v8,
    output logic              v9,
    output logic              v10,
    output logic              v11,
    output logic              v12,
    output logic              scan_out,
    output logic              busy,
    output logic              scan_ack,
    output logic [CNT_W-1:0]  cap_cnt
);

    // Shift counter only needs to reach NSTATE-1.
    localparam int SC_W = (NSTATE > 1) ? $clog2(NSTATE) : 1;
    localparam logic [SC_W-1:0] LAST_SHIFT = SC_W'(NSTATE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } fsm_e;

    fsm_e              fsm_q,       fsm_d;
    logic [NSTATE-1:0] state_q,     state_d;
    logic [SC_W-1:0]   shift_cnt_q, shift_cnt_d;
    logic [CNT_W-1:0]  cap_cnt_q,   cap_cnt_d;

    always_ff @(posedge CK or negedge CLR) begin
        if (!CLR) begin
            fsm_q       <= IDLE;
            state_q     <= CLR_VAL;
            shift_cnt_q <= '0;
            cap_cnt_q   <= '0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            shift_cnt_q <= shift_cnt_d;
            cap_cnt_q   <= cap_cnt_d;
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        shift_cnt_d = shift_cnt_q;
        cap_cnt_d   = cap_cnt_q;
        unique case (fsm_q)
            IDLE: begin
                // A scan request wins over a simultaneous functional capture.
                if (scan_req) begin
                    fsm_d       = SHIFT;
                    shift_cnt_d = '0;
                end else if (cap_en) begin
                    state_d   = ns_in;
                    cap_cnt_d = cap_cnt_q + CNT_W'(1);
                end
            end
            SHIFT: begin
                // Shift toward bit 0 so the old v7 appears first on scan_out.
                state_d     = {scan_in, state_q[NSTATE-1:1]};
                shift_cnt_d = shift_cnt_q + SC_W'(1);
                if (shift_cnt_q == LAST_SHIFT) begin
                    fsm_d = DONE;
                end
            end
            DONE: begin
                fsm_d = IDLE;
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // All outputs come straight from flops or decode of the FSM register.
    assign busy     = (fsm_q != IDLE);
    assign scan_ack = (fsm_q == DONE);
    assign scan_out = state_q[0];
    assign cap_cnt  = cap_cnt_q;

    // The v7..v12 names fix this block at six state bits.
    assign v7  = state_q[0];
    assign v8  = state_q[1];
    assign v9  = state_q[2];
    assign v10 = state_q[3];
    assign v11 = state_q[4];
    assign v12 = state_q[5];

endmodule

// File: tb/tb_s1488_state_reg.sv
module tb_s1488_state_reg;

    logic       CK = 1'b0;
    logic       CLR = 1'b1;
    logic [5:0] ns_in = '0;
    logic       cap_en = 1'b0;
    logic       scan_req = 1'b0;
    logic       scan_in = 1'b0;
    logic       v7, v8, v9, v10, v11, v12;
    logic       scan_out, busy, scan_ack;
    logic [7:0] cap_cnt;

    logic [5:0] dut_st;
    assign dut_st = {v12, v11, v10, v9, v8, v7};

    s1488_state_reg dut (
        .CK       (CK),
        .CLR      (CLR),
        .ns_in    (ns_in),
        .cap_en   (cap_en),
        .scan_req (scan_req),
        .scan_in  (scan_in),
        .v7       (v7),
        .v8       (v8),
        .v9       (v9),
        .v10      (v10),
        .v11      (v11),
        .v12      (v12),
        .scan_out (scan_out),
        .busy     (busy),
        .scan_ack (scan_ack),
        .cap_cnt  (cap_cnt)
    );

    always #5 CK = ~CK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: state as an integer, scan progress as "shifts remaining".
    int m_state = 0;
    int m_cnt   = 0;
    int m_rem   = 0;
    bit m_done  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ".state"}, 32'(dut_st), 32'(m_state));
        chk({where, ".busy"},  32'(busy),   ((m_rem > 0) || m_done) ? 32'd1 : 32'd0);
        chk({where, ".ack"},   32'(scan_ack), m_done ? 32'd1 : 32'd0);
        chk({where, ".sout"},  32'(scan_out), 32'(m_state % 2));
        chk({where, ".cnt"},   32'(cap_cnt),  32'(m_cnt));
    endtask

    // Drive inputs, take one rising edge, advance the model, check 1ns later.
    task automatic step(input logic cap, input logic req, input logic si, input logic [5:0] ns);
        cap_en   = cap;
        scan_req = req;
        scan_in  = si;
        ns_in    = ns;
        @(posedge CK);
        if (m_done) begin
            m_done = 1'b0;
        end else if (m_rem > 0) begin
            m_state = (m_state / 2) + (si ? 32 : 0);
            m_rem--;
            if (m_rem == 0) m_done = 1'b1;
        end else if (req) begin
            m_rem = 6;
        end else if (cap) begin
            m_state = int'(ns);
            m_cnt   = (m_cnt + 1) % 256;
        end
        #1;
        check_all("step");
    endtask

    // Assert reset away from any edge and check it acts without a clock.
    task automatic apply_reset(input string where);
        cap_en   = 1'b0;
        scan_req = 1'b0;
        scan_in  = 1'b0;
        #2;
        CLR = 1'b0;
        m_state = 0;
        m_cnt   = 0;
        m_rem   = 0;
        m_done  = 1'b0;
        #1;
        check_all(where);
        @(negedge CK);
        CLR = 1'b1;
        @(posedge CK);
        #1;
        check_all({where, ".rel"});
    endtask

    initial begin
        logic [5:0] si_pat;
        logic [5:0] sout_pat;
        logic [5:0] hold_st;
        logic [5:0] last_ns;
        int         bc, ac, ack_at;
        logic [7:0] cnt_before;

        // 1: reset
        #2;
        apply_reset("reset");
        chk("reset.v", 32'(dut_st), 32'd0);

        // 2: capture, then hold
        step(1'b1, 1'b0, 1'b0, 6'b101101);
        chk("cap.state", 32'(dut_st), 32'b101101);
        chk("cap.cnt",   32'(cap_cnt), 32'd1);
        hold_st = dut_st;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'($urandom), 6'($urandom));
        chk("hold.state", 32'(dut_st), 32'(hold_st));

        // 3: scan out 000111 while shifting in 1,0,1,0,1,0
        step(1'b1, 1'b0, 1'b0, 6'b000111);
        si_pat   = 6'b010101;
        sout_pat = 6'b000111;
        step(1'b0, 1'b1, 1'b0, 6'($urandom));
        bc = busy ? 1 : 0;
        ac = 0;
        ack_at = 0;
        for (int i = 0; i < 6; i++) begin
            chk("scan.sout_seq", 32'(scan_out), 32'(sout_pat[i]));
            step(1'b0, 1'b0, si_pat[i], 6'($urandom));
            if (busy) bc++;
            if (scan_ack) begin ac++; ack_at = i + 2; end
        end
        chk("scan.final", 32'(dut_st), 32'b010101);
        step(1'b0, 1'b0, 1'b0, 6'($urandom));
        if (busy) bc++;
        if (scan_ack) ac++;
        chk("scan.busy_cycles", 32'(bc), 32'd7);
        chk("scan.ack_cycles",  32'(ac), 32'd1);
        chk("scan.ack_at",      32'(ack_at), 32'd7);

        // 4: scan_req beats cap_en; cap_en ignored while shifting
        cnt_before = cap_cnt;
        step(1'b1, 1'b1, 1'b0, 6'($urandom));
        chk("prio.busy", 32'(busy), 32'd1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'($urandom), 1'($urandom), 6'($urandom));
        chk("prio.cnt", 32'(cap_cnt), 32'(cnt_before));

        // 5: abort after 3 of 6 shifts, then a clean scan
        step(1'b1, 1'b0, 1'b0, 6'b111111);
        step(1'b0, 1'b1, 1'b0, 6'($urandom));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 6'($urandom));
        apply_reset("abort");
        chk("abort.state", 32'(dut_st), 32'd0);
        chk("abort.ack",   32'(scan_ack), 32'd0);
        step(1'b0, 1'b1, 1'b0, 6'($urandom));
        ac = 0;
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b0, 1'b1, 6'($urandom));
            if (scan_ack) ac++;
        end
        chk("abort.rescan_ack", 32'(ac), 32'd1);
        chk("abort.rescan_state", 32'(dut_st), 32'b111111);

        // 6: counter wrap
        apply_reset("wrap_rst");
        last_ns = '0;
        for (int i = 0; i < 256; i++) begin
            last_ns = 6'($urandom);
            step(1'b1, 1'b0, 1'b0, last_ns);
        end
        chk("wrap.cnt",   32'(cap_cnt), 32'd0);
        chk("wrap.state", 32'(dut_st), 32'(last_ns));

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), 1'($urandom), 6'($urandom));
            if ($urandom_range(0, 199) == 0) apply_reset("rand_rst");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
